dds_sweep_ctrl: RTL and testbench

//  Sequencer driving the DDS core's FREQW/PHASEW inputs. Host writes start/stop/step/dwell/phase

---
 rtl/dds_sweep_pkg.sv | 42 ++++
 rtl/dds_sweep_regs.sv | 54 +++++
 rtl/dds_sweep_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS frequency sweep controller.
package dds_sweep_pkg;

  localparam int unsigned FREQ_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [2:0] ADDR_START_F = 3'd0;
  localparam logic [2:0] ADDR_STOP_F  = 3'd1;
  localparam logic [2:0] ADDR_STEP_F  = 3'd2;
  localparam logic [2:0] ADDR_DWELL   = 3'd3;
  localparam logic [2:0] ADDR_PHASE   = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  localparam int unsigned CTRL_REPEAT_BIT = 0;
  localparam int unsigned CTRL_DIR_BIT    = 1;

  // Upward step with carry kept in bit 32; anything past the limit clamps to it.
  function automatic logic [FREQ_WIDTH-1:0] clamp_up(input logic [FREQ_WIDTH-1:0] f,
                                                     input logic [FREQ_WIDTH-1:0] step,
                                                     input logic [FREQ_WIDTH-1:0] lim);
    logic [FREQ_WIDTH:0] nxt;
    nxt = (FREQ_WIDTH+1)'(f) + (FREQ_WIDTH+1)'(step);
    return (nxt > (FREQ_WIDTH+1)'(lim)) ? lim : nxt[FREQ_WIDTH-1:0];
  endfunction

  // Downward step; a borrow or undershoot clamps to the lower limit.
  function automatic logic [FREQ_WIDTH-1:0] clamp_dn(input logic [FREQ_WIDTH-1:0] f,
                                                     input logic [FREQ_WIDTH-1:0] step,
                                                     input logic [FREQ_WIDTH-1:0] lim);
    logic [FREQ_WIDTH:0] nxt;
    nxt = (FREQ_WIDTH+1)'(f) - (FREQ_WIDTH+1)'(step);
    return (nxt[FREQ_WIDTH] || (nxt[FREQ_WIDTH-1:0] < lim)) ? lim : nxt[FREQ_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dds_sweep_regs.sv
// Host-writable shadow register file for the sweep controller.
// SWEEP_TRIANGLE_EN adds the CTRL direction bit; otherwise it is not stored.
module dds_sweep_regs
  import dds_sweep_pkg::*;
#(
  parameter int unsigned ROMAD_WIDTH = 8,
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic                   DDS_CLK,
  input  logic                   RST_N,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            start_f,
  output logic [31:0]            stop_f,
  output logic [31:0]            step_f,
  output logic [DWELL_WIDTH-1:0] dwell,
  output logic [ROMAD_WIDTH-1:0] phase,
`ifdef SWEEP_TRIANGLE_EN
  output logic                   ctrl_dir,
`endif
  output logic                   ctrl_repeat
);

  always_ff @(posedge DDS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_f     <= '0;
      stop_f      <= '0;
      step_f      <= '0;
      dwell       <= '0;
      phase       <= '0;
      ctrl_repeat <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      ctrl_dir    <= 1'b0;
`endif
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_START_F: start_f <= cfg_wdata;
        ADDR_STOP_F:  stop_f  <= cfg_wdata;
        ADDR_STEP_F:  step_f  <= cfg_wdata;
        ADDR_DWELL:   dwell   <= cfg_wdata[DWELL_WIDTH-1:0];
        ADDR_PHASE:   phase   <= cfg_wdata[ROMAD_WIDTH-1:0];
        ADDR_CTRL: begin
          ctrl_repeat <= cfg_wdata[CTRL_REPEAT_BIT];
`ifdef SWEEP_TRIANGLE_EN
          ctrl_dir    <= cfg_wdata[CTRL_DIR_BIT];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding the DDS FREQW/PHASEW inputs.
// Define SWEEP_TRIANGLE_EN to enable up/down (triangle) sweeps via CTRL[1].
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned ROMAD_WIDTH = 8,
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic                   DDS_CLK,
  input  logic                   RST_N,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  input  logic                   cmd_start,
  input  logic                   cmd_abort,
  output logic [31:0]            FREQW,
  output logic [ROMAD_WIDTH-1:0] PHASEW,
  output logic                   busy,
  output logic                   done
);

  logic [31:0]            sh_start, sh_stop, sh_step;
  logic [DWELL_WIDTH-1:0] sh_dwell;
  logic [ROMAD_WIDTH-1:0] sh_phase;
  logic                   sh_repeat;

  logic [31:0]            act_start, act_stop, act_step;
  logic [DWELL_WIDTH-1:0] act_dwell;
  logic                   act_repeat;

  state_t                 state, state_nxt;
  logic [31:0]            freqw_nxt;
  logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;
  logic                   busy_nxt, done_nxt;
  logic                   load_c, advance_c;

`ifdef SWEEP_TRIANGLE_EN
  logic sh_dir, act_dir, down, down_nxt;
`endif

  dds_sweep_regs #(
    .ROMAD_WIDTH (ROMAD_WIDTH),
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_regs (
    .DDS_CLK     (DDS_CLK),
    .RST_N       (RST_N),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start_f     (sh_start),
    .stop_f      (sh_stop),
    .step_f      (sh_step),
    .dwell       (sh_dwell),
    .phase       (sh_phase),
`ifdef SWEEP_TRIANGLE_EN
    .ctrl_dir    (sh_dir),
`endif
    .ctrl_repeat (sh_repeat)
  );

  // Next-state and datapath decisions; abort always wins and freezes FREQW.
  always_comb begin
    state_nxt     = state;
    freqw_nxt     = FREQW;
    dwell_cnt_nxt = dwell_cnt;
    load_c        = 1'b0;
    advance_c     = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
    down_nxt      = down;
`endif

    case (state)
      ST_IDLE: begin
        if (cmd_start && !cmd_abort) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (cmd_abort) begin
          state_nxt = ST_DONE;
        end else begin
          load_c    = 1'b1;
          freqw_nxt = sh_start;
`ifdef SWEEP_TRIANGLE_EN
          down_nxt  = 1'b0;
`endif
          if ((sh_step == '0) || (sh_start > sh_stop)) begin
            state_nxt = ST_DONE;
          end else begin
            dwell_cnt_nxt = sh_dwell;
            state_nxt     = (sh_dwell == '0) ? ST_STEP : ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        if (cmd_abort) begin
          state_nxt = ST_DONE;
        end else begin
          dwell_cnt_nxt = dwell_cnt - DWELL_WIDTH'(1);
          if (dwell_cnt <= DWELL_WIDTH'(1)) state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (cmd_abort) begin
          state_nxt = ST_DONE;
        end else begin
          advance_c = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
          if (!down) begin
            if (FREQW == act_stop) begin
              if (act_dir && (act_stop != act_start)) begin
                down_nxt  = 1'b1;
                freqw_nxt = clamp_dn(FREQW, act_step, act_start);
              end else if (act_repeat) begin
                freqw_nxt = act_start;
              end else begin
                advance_c = 1'b0;
              end
            end else begin
              freqw_nxt = clamp_up(FREQW, act_step, act_stop);
            end
          end else begin
            if (FREQW == act_start) begin
              if (act_repeat) begin
                down_nxt  = 1'b0;
                freqw_nxt = clamp_up(FREQW, act_step, act_stop);
              end else begin
                advance_c = 1'b0;
              end
            end else begin
              freqw_nxt = clamp_dn(FREQW, act_step, act_start);
            end
          end
`else
          if (FREQW == act_stop) begin
            if (act_repeat) freqw_nxt = act_start;
            else            advance_c = 1'b0;
          end else begin
            freqw_nxt = clamp_up(FREQW, act_step, act_stop);
          end
`endif
          if (advance_c) begin
            dwell_cnt_nxt = act_dwell;
            state_nxt     = (act_dwell == '0) ? ST_STEP : ST_DWELL;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_DWELL) || (state_nxt == ST_STEP);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge DDS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      FREQW     <= '0;
      dwell_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      down      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      FREQW     <= freqw_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef SWEEP_TRIANGLE_EN
      down      <= down_nxt;
`endif
    end
  end

  // Shadow-to-active copy happens only on an un-aborted LOAD cycle.
  always_ff @(posedge DDS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      act_start  <= '0;
      act_stop   <= '0;
      act_step   <= '0;
      act_dwell  <= '0;
      act_repeat <= 1'b0;
      PHASEW     <= '0;
`ifdef SWEEP_TRIANGLE_EN
      act_dir    <= 1'b0;
`endif
    end else if (load_c) begin
      act_start  <= sh_start;
      act_stop   <= sh_stop;
      act_step   <= sh_step;
      act_dwell  <= sh_dwell;
      act_repeat <= sh_repeat;
      PHASEW     <= sh_phase;
`ifdef SWEEP_TRIANGLE_EN
      act_dir    <= sh_dir;
`endif
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed, table-driven bench for dds_sweep_ctrl (default sawtooth build).
module tb_dds_sweep_ctrl;
  import dds_sweep_pkg::*;

  logic        DDS_CLK = 1'b0;
  logic        RST_N;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cmd_start, cmd_abort;
  logic [31:0] FREQW;
  logic [7:0]  PHASEW;
  logic        busy, done;

  int total  = 0;
  int passed = 0;

  always #5 DDS_CLK = ~DDS_CLK;

  dds_sweep_ctrl #(.ROMAD_WIDTH(8), .DWELL_WIDTH(24)) dut (
    .DDS_CLK   (DDS_CLK),
    .RST_N     (RST_N),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cmd_start (cmd_start),
    .cmd_abort (cmd_abort),
    .FREQW     (FREQW),
    .PHASEW    (PHASEW),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [31:0]      start;
    logic [31:0]      stop;
    logic [31:0]      step;
    logic [23:0]      dwell;
    logic [7:0]       phase;
    int               n;
    logic [5:0][31:0] v;
  } vec_t;

  vec_t vt [7];

  logic [31:0] got_v [16];
  int          got_h [16];
  int          got_n;
  bit          seen_done, busy_bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    else passed++;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge DDS_CLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic configure(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [31:0] dw, input logic [31:0] ph, input logic [31:0] ctrl);
    cfg_write(ADDR_START_F, s);
    cfg_write(ADDR_STOP_F, e);
    cfg_write(ADDR_STEP_F, st);
    cfg_write(ADDR_DWELL, dw);
    cfg_write(ADDR_PHASE, ph);
    cfg_write(ADDR_CTRL, ctrl);
  endtask

  task automatic start_cmd(input string name);
    cmd_start = 1'b1;
    @(posedge DDS_CLK); #1;
    cmd_start = 1'b0;
    chk(name, 32'(busy), 32'd1);
  endtask

  // Samples every cycle until done, run-length encoding FREQW; optional mid-sweep write.
  task automatic capture(input bit mid_we, input logic [2:0] mid_addr, input logic [31:0] mid_data);
    got_n = 0; seen_done = 1'b0; busy_bad = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      if (c == 2 && mid_we) begin
        cfg_we = 1'b1; cfg_addr = mid_addr; cfg_wdata = mid_data;
      end
      @(posedge DDS_CLK); #1;
      cfg_we = 1'b0;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (!busy) busy_bad = 1'b1;
        if (got_n > 0 && FREQW == got_v[got_n-1]) begin
          got_h[got_n-1]++;
        end else if (got_n < 16) begin
          got_v[got_n] = FREQW;
          got_h[got_n] = 1;
          got_n++;
        end
      end
    end
  endtask

  logic [31:0] exp_last;
  logic [31:0] rep_exp [9];

  initial begin
    RST_N = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cmd_start = 1'b0; cmd_abort = 1'b0;

    vt[0] = '{start: 32'd100, stop: 32'd400, step: 32'd100, dwell: 24'd2, phase: 8'h11, n: 4, v: '0};
    vt[0].v[0] = 32'd100; vt[0].v[1] = 32'd200; vt[0].v[2] = 32'd300; vt[0].v[3] = 32'd400;
    vt[1] = '{start: 32'd0, stop: 32'd250, step: 32'd100, dwell: 24'd0, phase: 8'h22, n: 4, v: '0};
    vt[1].v[0] = 32'd0; vt[1].v[1] = 32'd100; vt[1].v[2] = 32'd200; vt[1].v[3] = 32'd250;
    vt[2] = '{start: 32'hFFFF_FF00, stop: 32'hFFFF_FFFF, step: 32'h200, dwell: 24'd1, phase: 8'h33, n: 2, v: '0};
    vt[2].v[0] = 32'hFFFF_FF00; vt[2].v[1] = 32'hFFFF_FFFF;
    vt[3] = '{start: 32'd55, stop: 32'd55, step: 32'd7, dwell: 24'd3, phase: 8'h44, n: 1, v: '0};
    vt[3].v[0] = 32'd55;
    vt[4] = '{start: 32'd10, stop: 32'd100, step: 32'd0, dwell: 24'd2, phase: 8'h55, n: 0, v: '0};
    vt[5] = '{start: 32'd500, stop: 32'd100, step: 32'd10, dwell: 24'd0, phase: 8'h66, n: 0, v: '0};
    vt[6] = '{start: 32'd5, stop: 32'd35, step: 32'd10, dwell: 24'd1, phase: 8'h77, n: 4, v: '0};
    vt[6].v[0] = 32'd5; vt[6].v[1] = 32'd15; vt[6].v[2] = 32'd25; vt[6].v[3] = 32'd35;

    repeat (2) @(posedge DDS_CLK);
    #1;
    chk("rst_freqw", FREQW, 32'd0);
    chk("rst_phasew", 32'(PHASEW), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    RST_N = 1'b1;
    @(posedge DDS_CLK); #1;

    for (int i = 0; i < 7; i++) begin
      configure(vt[i].start, vt[i].stop, vt[i].step, 32'(vt[i].dwell), 32'(vt[i].phase), 32'd0);
      start_cmd($sformatf("v%0d_busy_rise", i));
      capture(1'b0, 3'd0, 32'd0);
      chk($sformatf("v%0d_done_seen", i), 32'(seen_done), 32'd1);
      chk($sformatf("v%0d_busy_during", i), 32'(busy_bad), 32'd0);
      chk($sformatf("v%0d_count", i), 32'(got_n), 32'(vt[i].n));
      for (int k = 0; k < vt[i].n; k++) begin
        chk($sformatf("v%0d_freq%0d", i, k), got_v[k], vt[i].v[k]);
        chk($sformatf("v%0d_hold%0d", i, k), 32'(got_h[k]), 32'(vt[i].dwell) + 32'd1);
      end
      exp_last = (vt[i].n == 0) ? vt[i].start : vt[i].v[vt[i].n-1];
      chk($sformatf("v%0d_done_freq", i), FREQW, exp_last);
      chk($sformatf("v%0d_done_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_phase", i), 32'(PHASEW), 32'(vt[i].phase));
      @(posedge DDS_CLK); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_idle_freq", i), FREQW, exp_last);
    end

    // Repeat sweep, abort mid-dwell, start+abort in idle, restart.
    configure(32'd10, 32'd30, 32'd10, 32'd1, 32'h3C, 32'd1);
    rep_exp = '{32'd10, 32'd10, 32'd20, 32'd20, 32'd30, 32'd30, 32'd10, 32'd10, 32'd20};
    start_cmd("rep_busy_rise");
    for (int k = 0; k < 9; k++) begin
      @(posedge DDS_CLK); #1;
      chk($sformatf("rep_freq%0d", k), FREQW, rep_exp[k]);
    end
    cmd_abort = 1'b1;
    @(posedge DDS_CLK); #1;
    cmd_abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_freq", FREQW, 32'd20);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge DDS_CLK); #1;
    chk("abort_done_fall", 32'(done), 32'd0);
    chk("abort_freq_hold", FREQW, 32'd20);
    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(posedge DDS_CLK); #1;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    chk("both_busy", 32'(busy), 32'd0);
    @(posedge DDS_CLK); #1;
    chk("both_busy2", 32'(busy), 32'd0);
    chk("both_freq", FREQW, 32'd20);
    start_cmd("restart_busy");
    @(posedge DDS_CLK); #1;
    chk("restart_freq", FREQW, 32'd10);
    chk("restart_phase", 32'(PHASEW), 32'h3C);
    cmd_abort = 1'b1;
    @(posedge DDS_CLK); #1;
    cmd_abort = 1'b0;
    chk("restart_abort_done", 32'(done), 32'd1);
    chk("restart_abort_freq", FREQW, 32'd10);
    @(posedge DDS_CLK); #1;

    // Shadow isolation: STEP_F rewritten mid-sweep applies only to the next start.
    configure(32'd100, 32'd400, 32'd100, 32'd2, 32'h01, 32'd0);
    start_cmd("iso_busy");
    capture(1'b1, ADDR_STEP_F, 32'd300);
    chk("iso_count", 32'(got_n), 32'd4);
    chk("iso_f1", got_v[1], 32'd200);
    chk("iso_f2", got_v[2], 32'd300);
    @(posedge DDS_CLK); #1;
    start_cmd("iso2_busy");
    capture(1'b0, 3'd0, 32'd0);
    chk("iso2_count", 32'(got_n), 32'd2);
    chk("iso2_f0", got_v[0], 32'd100);
    chk("iso2_f1", got_v[1], 32'd400);
    @(posedge DDS_CLK); #1;

    // Asynchronous reset mid-sweep clears outputs and shadow registers.
    configure(32'd100, 32'd400, 32'd100, 32'd2, 32'h5A, 32'd0);
    start_cmd("rstm_busy");
    repeat (4) @(posedge DDS_CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("rstm_freqw", FREQW, 32'd0);
    chk("rstm_phasew", 32'(PHASEW), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_done", 32'(done), 32'd0);
    @(posedge DDS_CLK); #1;
    RST_N = 1'b1;
    @(posedge DDS_CLK); #1;
    start_cmd("post_rst_busy");
    @(posedge DDS_CLK); #1;
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_freq", FREQW, 32'd0);
    @(posedge DDS_CLK); #1;
    chk("post_rst_done_fall", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
